// File: rtl/pipe_stage_skid_pkg.sv
// Shared encodings for the pipeline stage register.
// The state encoding doubles as the occupancy count.
package pipe_stage_skid_pkg;

    localparam int unsigned PSTAGE_STATE_W = 2;

    localparam logic [PSTAGE_STATE_W-1:0] PSTAGE_EMPTY = 2'd0;
    localparam logic [PSTAGE_STATE_W-1:0] PSTAGE_HALF  = 2'd1;
    localparam logic [PSTAGE_STATE_W-1:0] PSTAGE_FULL  = 2'd2;

    function automatic logic [PSTAGE_STATE_W-1:0] pstage_count(
        input logic [PSTAGE_STATE_W-1:0] state
    );
        return state;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline stage register: upstream, downstream and flush.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface pipe_stage_skid_if
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned WIDTH = 64
);
    logic                      flush_valid_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [WIDTH-1:0]          in_data_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [WIDTH-1:0]          out_data_o;
    logic [PSTAGE_STATE_W-1:0] count_o;

    modport slave (
        input  flush_valid_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );

    modport master (
        output flush_valid_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// Single payload register with async reset to the bubble value.
// Bubble load wins over a data load.
module pipe_stage_skid_slot #(
    parameter int unsigned      WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= BUBBLE_VAL;
        end else if (i_bubble) begin
            r_data <= BUBBLE_VAL;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with flush-to-bubble and an optional
// skid slot that registers in_ready_o.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned      WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter bit               SKID       = 1'b1
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_skid_if.slave bus
);
    logic [PSTAGE_STATE_W-1:0] r_state;
    logic [PSTAGE_STATE_W-1:0] w_state_next;
    logic                      w_accept;
    logic                      w_drain;
    logic                      w_in_ready;
    logic                      w_out_valid;
    logic                      w_main_load;
    logic                      w_main_bubble;
    logic                      w_main_from_skid;
    logic                      w_skid_load;
    logic                      w_skid_bubble;
    logic [WIDTH-1:0]          w_main_data;
    logic [WIDTH-1:0]          w_skid_data;
    logic [WIDTH-1:0]          w_main_d;

    assign w_out_valid = (r_state != PSTAGE_EMPTY);

    generate
        if (SKID) begin : g_ready_reg
            assign w_in_ready = (r_state != PSTAGE_FULL);
        end else begin : g_ready_comb
            assign w_in_ready = !w_out_valid || bus.out_ready_i;
        end
    endgenerate

    assign w_accept = bus.in_valid_i && w_in_ready;
    assign w_drain  = w_out_valid && bus.out_ready_i;

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_bubble    = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_bubble    = 1'b0;
        if (bus.flush_valid_i) begin
            w_state_next  = PSTAGE_EMPTY;
            w_main_bubble = 1'b1;
            w_skid_bubble = 1'b1;
        end else begin
            case (r_state)
                PSTAGE_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = PSTAGE_HALF;
                        w_main_load  = 1'b1;
                    end
                end
                PSTAGE_HALF: begin
                    if (w_accept && w_drain) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = PSTAGE_FULL;
                        w_skid_load  = 1'b1;
                    end else if (w_drain) begin
                        w_state_next  = PSTAGE_EMPTY;
                        w_main_bubble = 1'b1;
                    end
                end
                PSTAGE_FULL: begin
                    if (w_drain) begin
                        w_state_next     = PSTAGE_HALF;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_bubble    = 1'b1;
                    end
                end
                default: begin
                    w_state_next  = PSTAGE_EMPTY;
                    w_main_bubble = 1'b1;
                    w_skid_bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PSTAGE_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_data : bus.in_data_i;

    pipe_stage_skid_slot #(
        .WIDTH      (WIDTH),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_main_slot (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_main_load),
        .i_bubble (w_main_bubble),
        .i_data   (w_main_d),
        .o_data   (w_main_data)
    );

    generate
        if (SKID) begin : g_skid_slot
            pipe_stage_skid_slot #(
                .WIDTH      (WIDTH),
                .BUBBLE_VAL (BUBBLE_VAL)
            ) u_skid_slot (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_skid_load),
                .i_bubble (w_skid_bubble),
                .i_data   (bus.in_data_i),
                .o_data   (w_skid_data)
            );
        end else begin : g_no_skid_slot
            // FULL is unreachable here, so the skid path is never selected.
            assign w_skid_data = BUBBLE_VAL;
        end
    endgenerate

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = w_main_data;
    assign bus.count_o     = pstage_count(r_state);
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed-vector and reference-queue bench for pipe_stage_skid in both
// SKID=1 (bus1/u_dut1) and SKID=0 (bus0/u_dut0) configurations.
module tb_pipe_stage_skid;
    localparam int unsigned W = 16;
    localparam logic [W-1:0] BUB = 16'hDEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_skid_if #(.WIDTH(W)) bus1 ();
    pipe_stage_skid_if #(.WIDTH(W)) bus0 ();

    pipe_stage_skid #(.WIDTH(W), .BUBBLE_VAL(BUB), .SKID(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    pipe_stage_skid #(.WIDTH(W), .BUBBLE_VAL(BUB), .SKID(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic         flush;
        logic         vld;
        logic [W-1:0] din;
        logic         rdy;
        logic         e_vld;
        logic [W-1:0] e_dat;
        logic [1:0]   e_cnt;
        logic         e_in_rdy;
    } vec_t;

    vec_t vecs[16];

    task automatic drive1(input logic f, input logic v, input logic [W-1:0] d, input logic r);
        bus1.flush_valid_i = f;
        bus1.in_valid_i    = v;
        bus1.in_data_i     = d;
        bus1.out_ready_i   = r;
    endtask

    task automatic drive0(input logic f, input logic v, input logic [W-1:0] d, input logic r);
        bus0.flush_valid_i = f;
        bus0.in_valid_i    = v;
        bus0.in_data_i     = d;
        bus0.out_ready_i   = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic f1, v1, r1, f0, v0, r0, m_rdy1, m_rdy0, acc1, acc0, drn1, drn0;
        logic [W-1:0] d1, d0;

        // stream 1,2,3, then stall with A held and B skidded, then flush cases
        vecs[0]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002, 2'd1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 16'h0003, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 16'h000A, 1'b1, 1'b1, 16'h000A, 2'd1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 16'h000B, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h000E, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000B, 2'd1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, BUB,      2'd0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 16'h0011, 2'd1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 16'h0011, 2'd2, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'h000C, 1'b0, 1'b0, BUB,      2'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 16'h0021, 1'b1, 1'b1, 16'h0021, 2'd1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, BUB,      2'd0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, BUB,      2'd0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 16'h0031, 1'b0, 1'b1, 16'h0031, 2'd1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0031, 2'd1, 1'b1};

        drive1(1'b0, 1'b0, '0, 1'b0);
        drive0(1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset s1 out_valid", 32'(bus1.out_valid_o), 32'd0);
        chk("reset s1 out_data",  32'(bus1.out_data_o),  32'(BUB));
        chk("reset s1 count",     32'(bus1.count_o),     32'd0);
        chk("reset s1 in_ready",  32'(bus1.in_ready_o),  32'd1);
        chk("reset s0 out_valid", 32'(bus0.out_valid_o), 32'd0);
        chk("reset s0 out_data",  32'(bus0.out_data_o),  32'(BUB));
        chk("reset s0 in_ready",  32'(bus0.in_ready_o),  32'd1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive1(vecs[i].flush, vecs[i].vld, vecs[i].din, vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(bus1.out_valid_o), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d out_data", i),  32'(bus1.out_data_o),  32'(vecs[i].e_dat));
            chk($sformatf("vec%0d count", i),     32'(bus1.count_o),     32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d in_ready", i),  32'(bus1.in_ready_o),  32'(vecs[i].e_in_rdy));
        end
        drive1(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive1(1'b0, 1'b0, '0, 1'b0);

        // SKID=0: combinational ready, back-to-back transfers
        drive0(1'b0, 1'b1, 16'h0040, 1'b1);
        #1 chk("s0 empty in_ready", 32'(bus0.in_ready_o), 32'd1);
        tick();
        chk("s0 first data", 32'(bus0.out_data_o), 32'h40);
        chk("s0 first count", 32'(bus0.count_o), 32'd1);
        drive0(1'b0, 1'b1, 16'h0041, 1'b0);
        #1 chk("s0 stall in_ready", 32'(bus0.in_ready_o), 32'd0);
        tick();
        chk("s0 stall hold data", 32'(bus0.out_data_o), 32'h40);
        chk("s0 stall count", 32'(bus0.count_o), 32'd1);
        bus0.out_ready_i = 1'b1;
        #1 chk("s0 release in_ready", 32'(bus0.in_ready_o), 32'd1);
        tick();
        chk("s0 b2b data1", 32'(bus0.out_data_o), 32'h41);
        drive0(1'b0, 1'b1, 16'h0042, 1'b1);
        tick();
        chk("s0 b2b data2", 32'(bus0.out_data_o), 32'h42);
        chk("s0 b2b count", 32'(bus0.count_o), 32'd1);
        drive0(1'b0, 1'b0, '0, 1'b1);
        tick();
        chk("s0 drained valid", 32'(bus0.out_valid_o), 32'd0);
        chk("s0 drained data", 32'(bus0.out_data_o), 32'(BUB));

        // async reset between edges while HALF with 0x55
        drive1(1'b0, 1'b1, 16'h0055, 1'b0);
        drive0(1'b0, 1'b1, 16'h0055, 1'b0);
        tick();
        chk("pre-rst s1 data", 32'(bus1.out_data_o), 32'h55);
        chk("pre-rst s0 data", 32'(bus0.out_data_o), 32'h55);
        drive1(1'b0, 1'b0, '0, 1'b0);
        drive0(1'b0, 1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst s1 out_valid", 32'(bus1.out_valid_o), 32'd0);
        chk("arst s1 out_data",  32'(bus1.out_data_o),  32'(BUB));
        chk("arst s1 in_ready",  32'(bus1.in_ready_o),  32'd1);
        chk("arst s1 count",     32'(bus1.count_o),     32'd0);
        chk("arst s0 out_valid", 32'(bus0.out_valid_o), 32'd0);
        chk("arst s0 out_data",  32'(bus0.out_data_o),  32'(BUB));
        chk("arst s0 in_ready",  32'(bus0.in_ready_o),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // randomised traffic against reference queues
        for (int c = 0; c < 300; c++) begin
            f1 = ($urandom_range(0, 15) == 0);
            v1 = $urandom_range(0, 1) == 1;
            r1 = $urandom_range(0, 2) != 0;
            d1 = W'($urandom);
            f0 = ($urandom_range(0, 15) == 0);
            v0 = $urandom_range(0, 1) == 1;
            r0 = $urandom_range(0, 2) != 0;
            d0 = W'($urandom);
            drive1(f1, v1, d1, r1);
            drive0(f0, v0, d0, r0);
            #1;
            m_rdy1 = (q1.size() < 2);
            m_rdy0 = (q0.size() == 0) || r0;
            chk("rnd s1 in_ready", 32'(bus1.in_ready_o), 32'(m_rdy1));
            chk("rnd s0 in_ready", 32'(bus0.in_ready_o), 32'(m_rdy0));
            acc1 = v1 && m_rdy1;
            acc0 = v0 && m_rdy0;
            drn1 = (q1.size() > 0) && r1;
            drn0 = (q0.size() > 0) && r0;
            tick();
            if (f1) q1.delete();
            else begin
                if (drn1) void'(q1.pop_front());
                if (acc1) q1.push_back(d1);
            end
            if (f0) q0.delete();
            else begin
                if (drn0) void'(q0.pop_front());
                if (acc0) q0.push_back(d0);
            end
            chk("rnd s1 out_valid", 32'(bus1.out_valid_o), 32'(q1.size() > 0));
            chk("rnd s1 out_data", 32'(bus1.out_data_o), 32'(q1.size() > 0 ? q1[0] : BUB));
            chk("rnd s1 count", 32'(bus1.count_o), 32'(q1.size()));
            chk("rnd s0 out_valid", 32'(bus0.out_valid_o), 32'(q0.size() > 0));
            chk("rnd s0 out_data", 32'(bus0.out_data_o), 32'(q0.size() > 0 ? q0[0] : BUB));
            chk("rnd s0 count", 32'(bus0.count_o), 32'(q0.size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the in-order core, successor to the fixed-field stall/flush stage registers between IF/ID/EX/MEM/WB. It carries one packed payload of `WIDTH` bits under a valid/ready handshake, with synchronous flush-to-bubble. An optional two-entry skid buffer gives a registered `in_ready_o` and breaks the combinational stall chain between stages. Stages instantiate it with their packed bus, for example the EX→MEM fields concatenated.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits.
- `BUBBLE_VAL`, default `WIDTH'b0`: payload value held in empty or flushed slots. Callers pack `INST_NOP`, `PCOP_NONE` and `MEMOP_NONE` into it.
- `SKID`, default 1: 1 selects the two-entry skid mode with registered ready; 0 selects a single entry whose ready is combinational from `out_ready_i`.

Ports:
- `clk` in 1: clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush_valid_i` in 1: synchronous flush, discards all held entries.
- `in_valid_i` in 1: upstream payload valid.
- `in_ready_o` out 1: stage can accept a payload this cycle.
- `in_data_i` in `WIDTH`: upstream payload.
- `out_valid_o` out 1: the main slot holds a live payload.
- `out_ready_i` in 1: downstream consumes this cycle.
- `out_data_o` out `WIDTH`: main slot contents; equals `BUBBLE_VAL` when not valid.
- `count_o` out 2: occupancy, 0..2.

## Operation
- Definitions:
  - accept = `in_valid_i & in_ready_o`
  - drain = `out_valid_o & out_ready_i`
- Storage is a main slot plus a skid slot (`SKID=1` only). State is EMPTY, HALF or FULL; `count_o` is 0, 1 or 2 respectively.
- EMPTY:
  - accept → HALF, main ← `in_data_i`.
- HALF:
  - accept and drain → HALF, main ← `in_data_i`.
  - accept only → FULL, skid ← `in_data_i`. With `SKID=0`, accept without drain is impossible.
  - drain only → EMPTY, main ← `BUBBLE_VAL`.
  - neither → hold.
- FULL:
  - drain → HALF, main ← skid, skid ← `BUBBLE_VAL`.
  - otherwise hold.
  - Accept cannot occur because ready is low.
- `in_ready_o`:
  - `SKID=1`: `state != FULL`, a pure function of registered state.
  - `SKID=0`: `!out_valid_o | out_ready_i`.
- `out_valid_o = (state != EMPTY)`.
- Ordering is strictly FIFO. No payload is duplicated or lost except by flush.
- Flush takes priority over everything in the same cycle:
  - Next state is EMPTY and both slots ← `BUBBLE_VAL`.
  - An accept in the flush cycle is discarded. Upstream is flushed by the same hazard unit.
  - A drain in the flush cycle counts as consumed by downstream.
- Reset: state EMPTY, both slots `BUBBLE_VAL`.
  - `out_valid_o` = 0.
  - `in_ready_o` = 1 in both modes.
  - `count_o` = 0.
  - Reset asserted mid-transfer drops all held payloads immediately, without waiting for a clock edge.

## Timing
- Latency: a payload accepted at edge N is visible on `out_data_o` and `out_valid_o` after edge N.
- Throughput: one payload per cycle while `out_ready_i` stays high, in both modes.
- `SKID=1`:
  - No combinational path from `out_ready_i` or `in_valid_i` to `in_ready_o`.
  - When `out_ready_i` drops, `in_ready_o` falls one cycle later. The one extra payload is absorbed by the skid slot.
- `SKID=0`: combinational path `out_ready_i` → `in_ready_o`. Use only where timing allows.
- All outputs are registered except `in_ready_o` when `SKID=0`.
- The flush effect is visible after the next edge; outputs are unaffected during the flush cycle itself.

## Structure
- State encodings `PSTAGE_EMPTY`, `PSTAGE_HALF` and `PSTAGE_FULL` (2 bits) go in `sysconfig.v` next to the existing pipeline defines.
- Natural sub-module: `pipe_stage_slot`, a single `WIDTH` data register with async reset to `BUBBLE_VAL`, a load enable and a load-bubble control.
  - It is instantiated twice.
  - Under `SKID=0` the skid instance is generated out.
- `regTemplate` is not reused because its reset style differs from this block's asynchronous reset.

## Test plan
- Reset, then `SKID=1` with `in_valid_i=1` and `out_ready_i=1` streaming 0x1,0x2,0x3 → `out_data_o` shows 0x1,0x2,0x3 on consecutive cycles, `count_o`=1, `in_ready_o` stays 1.
- `SKID=1`: feed 0xA, drop `out_ready_i` while 0xB is offered → 0xB lands in skid, `count_o`=2, `in_ready_o`=0 next cycle. Raise `out_ready_i` → outputs 0xA then 0xB, `in_ready_o` returns to 1.
- Flush while FULL with simultaneous `in_valid_i` (0xC) → next cycle `out_valid_o`=0, `out_data_o`=`BUBBLE_VAL`, `count_o`=0, and 0xC never appears.
- `SKID=0` with `out_ready_i`=0 and `out_valid_o`=1 → `in_ready_o`=0 in the same cycle. Set `out_ready_i`=1 → `in_ready_o`=1 combinationally and back-to-back transfer completes.
- Assert `rst` asynchronously between edges while HALF with payload 0x55 → `out_valid_o`=0, `out_data_o`=`BUBBLE_VAL` and `in_ready_o`=1 immediately, before the next edge.
- Randomised valid/ready with `SKID` 0 and 1 against a reference queue → output sequence equals the input sequence and `count_o` always matches queue depth.
